// File: rtl/tlul_err_steer.sv
// ============================================================================
//  Module   : tlul_err_steer (with tlul_pkg)
//  Brief    : Steers TL-UL requests to a device window or the error responder,
//             keeping responses in order. Optional macro: TLUL_STEER_ALIGN_CHK_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

    localparam logic [2:0] c_PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] c_PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] c_GET              = 3'h4;
    localparam logic [2:0] c_ACCESS_ACK       = 3'h0;
    localparam logic [2:0] c_ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_err_steer #(
    parameter logic [31:0] DEV_ADDR_BASE   = 32'h0000_0000,
    parameter logic [31:0] DEV_ADDR_MASK   = 32'h0000_0FFF,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tlul_pkg::tl_h2d_t tl_h_i,
    output tlul_pkg::tl_d2h_t tl_h_o,
    output tlul_pkg::tl_h2d_t tl_dev_o,
    input  tlul_pkg::tl_d2h_t tl_dev_i,
    output tlul_pkg::tl_h2d_t tl_err_o,
    input  tlul_pkg::tl_d2h_t tl_err_i
);

    localparam int unsigned        c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tgt;

    logic              w_hit;
    logic              w_sel;
    logic              w_busy;
    logic              w_stall;
    logic              w_d_valid;
    logic              w_a_ready;
    logic              w_acc;
    logic              w_ret;
    tlul_pkg::tl_d2h_t w_rsp;

    assign w_hit = (tl_h_i.a_address & ~DEV_ADDR_MASK) == DEV_ADDR_BASE;

`ifdef TLUL_STEER_ALIGN_CHK_EN
    logic [3:0] w_lanes;
    logic       w_bad_align;
    logic       w_bad_mask;

    always_comb begin
        w_lanes = 4'hF;
        case (tl_h_i.a_size)
            2'd0:    w_lanes = 4'b0001 << tl_h_i.a_address[1:0];
            2'd1:    w_lanes = 4'b0011 << {tl_h_i.a_address[1], 1'b0};
            default: w_lanes = 4'hF;
        endcase
    end

    assign w_bad_align = (tl_h_i.a_size == 2'd3)
                       || (tl_h_i.a_size == 2'd1 && tl_h_i.a_address[0])
                       || (tl_h_i.a_size == 2'd2 && tl_h_i.a_address[1:0] != 2'b00);
    assign w_bad_mask  = (tl_h_i.a_opcode == tlul_pkg::c_PUT_PARTIAL_DATA)
                       && ((tl_h_i.a_mask & ~w_lanes) != 4'h0);
    assign w_sel       = ~w_hit | w_bad_align | w_bad_mask;
`else
    assign w_sel = ~w_hit;
`endif

    // All outstanding requests share one target, so the D mux needs no per-beat tag.
    assign w_rsp     = r_tgt ? tl_err_i : tl_dev_i;
    assign w_busy    = (r_cnt != '0);
    assign w_d_valid = ~rst_i & w_busy & w_rsp.d_valid;
    assign w_ret     = w_d_valid & tl_h_i.d_ready;

    // A returning beat frees its slot in the same cycle: lets a full window
    // accept again and lets a target switch happen on the last response.
    assign w_stall   = (w_busy && (w_sel != r_tgt) && !(r_cnt == c_CNT_ONE && w_ret))
                     || (r_cnt == c_CNT_MAX && !w_ret);
    assign w_a_ready = ~rst_i & ~w_stall & (w_sel ? tl_err_i.a_ready : tl_dev_i.a_ready);
    assign w_acc     = tl_h_i.a_valid & w_a_ready;

    always_comb begin
        tl_dev_o         = tl_h_i;
        tl_dev_o.a_valid = ~rst_i & tl_h_i.a_valid & ~w_sel & ~w_stall;
        tl_dev_o.d_ready = ~rst_i & w_busy & ~r_tgt & tl_h_i.d_ready;

        tl_err_o         = tl_h_i;
        tl_err_o.a_valid = ~rst_i & tl_h_i.a_valid & w_sel & ~w_stall;
        tl_err_o.d_ready = ~rst_i & w_busy & r_tgt & tl_h_i.d_ready;

        tl_h_o           = w_rsp;
        tl_h_o.d_valid   = w_d_valid;
        tl_h_o.a_ready   = w_a_ready;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_tgt <= 1'b0;
        end else begin
            if (w_acc && !w_ret) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (!w_acc && w_ret) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            if (w_acc) begin
                r_tgt <= w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlul_err_steer.sv
// ============================================================================
//  Module   : tb_tlul_err_steer
//  Brief    : Directed bench for tlul_err_steer with a queue-based order model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlul_err_steer;
    import tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t h;
    tl_d2h_t h_rsp;
    tl_h2d_t dev_req;
    tl_d2h_t dev_rsp;
    tl_h2d_t err_req;
    tl_d2h_t err_rsp;

    int n_cmp  = 0;
    int n_fail = 0;

    // Target of every accepted, unanswered request, oldest first (1 = error port).
    bit q[$];

    always #5 clk = ~clk;

    tlul_err_steer dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tl_h_i   (h),
        .tl_h_o   (h_rsp),
        .tl_dev_o (dev_req),
        .tl_dev_i (dev_rsp),
        .tl_err_o (err_req),
        .tl_err_i (err_rsp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_sel(input tl_h2d_t a);
        bit          err;
        int unsigned nbytes;
        int unsigned off;
        err    = !(a.a_address <= 32'h0000_0FFF);
        nbytes = 1 << a.a_size;
        off    = a.a_address % 4;
`ifdef TLUL_STEER_ALIGN_CHK_EN
        if (a.a_size > 2) err = 1'b1;
        else if ((a.a_address % nbytes) != 0) err = 1'b1;
        else if (a.a_opcode == c_PUT_PARTIAL_DATA) begin
            for (int i = 0; i < 4; i++)
                if (a.a_mask[i] && !(i >= off && i < off + nbytes)) err = 1'b1;
        end
`endif
        return err;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst dev a_valid", dev_req.a_valid, 0);
            chk("rst err a_valid", err_req.a_valid, 0);
            chk("rst a_ready", h_rsp.a_ready, 0);
            chk("rst d_valid", h_rsp.d_valid, 0);
            chk("rst dev d_ready", dev_req.d_ready, 0);
            chk("rst err d_ready", err_req.d_ready, 0);
            q.delete();
        end else begin
            bit      tgt, sel, dv, ret, space, rdy, acc;
            int      left;
            tl_d2h_t src;
            tgt   = (q.size() > 0) ? q[0] : 1'b0;
            src   = tgt ? err_rsp : dev_rsp;
            dv    = (q.size() > 0) && src.d_valid;
            ret   = dv && h.d_ready;
            sel   = model_sel(h);
            left  = q.size() - int'(ret);
            space = (left < 4) && (left == 0 || tgt == sel);
            rdy   = space && (sel ? err_rsp.a_ready : dev_rsp.a_ready);
            acc   = h.a_valid && rdy;
            chk("dev a_valid", dev_req.a_valid, h.a_valid && !sel && space);
            chk("err a_valid", err_req.a_valid, h.a_valid && sel && space);
            chk("a_ready", h_rsp.a_ready, rdy);
            chk("d_valid", h_rsp.d_valid, dv);
            chk("dev d_ready", dev_req.d_ready, (q.size() > 0) && !tgt && h.d_ready);
            chk("err d_ready", err_req.d_ready, (q.size() > 0) && tgt && h.d_ready);
            chk("dev a_address", dev_req.a_address, h.a_address);
            chk("err a_mask", err_req.a_mask, h.a_mask);
            if (dv) begin
                chk("d_data", h_rsp.d_data, src.d_data);
                chk("d_error", h_rsp.d_error, src.d_error);
                chk("d_opcode", h_rsp.d_opcode, src.d_opcode);
            end
            if (ret) void'(q.pop_front());
            if (acc) q.push_back(sel);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        h                 = '0;
        h.d_ready         = 1'b1;
        h.a_opcode        = c_GET;
        h.a_size          = 2'd2;
        h.a_mask          = 4'hF;
        dev_rsp           = '0;
        dev_rsp.a_ready   = 1'b1;
        dev_rsp.d_opcode  = c_ACCESS_ACK_DATA;
        err_rsp           = '0;
        err_rsp.a_ready   = 1'b1;
        err_rsp.d_opcode  = c_ACCESS_ACK_DATA;
    endtask

    task automatic req(input logic [2:0] op, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [3:0] mask);
        h.a_valid   = 1'b1;
        h.a_opcode  = op;
        h.a_size    = sz;
        h.a_address = addr;
        h.a_mask    = mask;
        h.a_data    = addr ^ 32'h5A5A_0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        idle();
        rst = 1'b1;
        req(c_GET, 2'd2, 32'h10, 4'hF);
        repeat (3) begin
            @(negedge clk);
            chk("reset hold dev a_valid", dev_req.a_valid, 0);
            chk("reset hold err a_valid", err_req.a_valid, 0);
            chk("reset hold d_valid", h_rsp.d_valid, 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();
        chk("cnt after reset", dut.r_cnt, 0);

        // Single in-window Get, device answers next cycle.
        req(c_GET, 2'd2, 32'h0000_0010, 4'hF);
        @(negedge clk);
        chk("hit dev a_valid", dev_req.a_valid, 1);
        chk("hit err a_valid", err_req.a_valid, 0);
        cyc();
        chk("hit cnt 1", dut.r_cnt, 1);
        h.a_valid       = 1'b0;
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'hCAFE_0010;
        @(negedge clk);
        chk("hit d_data", h_rsp.d_data, 32'hCAFE_0010);
        cyc();
        dev_rsp.d_valid = 1'b0;
        chk("hit cnt 0", dut.r_cnt, 0);

        // Out-of-window Get answered by the error responder.
        req(c_GET, 2'd2, 32'h0000_2000, 4'hF);
        @(negedge clk);
        chk("miss err a_valid", err_req.a_valid, 1);
        chk("miss dev a_valid", dev_req.a_valid, 0);
        cyc();
        h.a_valid       = 1'b0;
        err_rsp.d_valid = 1'b1;
        err_rsp.d_error = 1'b1;
        err_rsp.d_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("miss d_error", h_rsp.d_error, 1);
        chk("miss d_opcode", h_rsp.d_opcode, c_ACCESS_ACK_DATA);
        cyc();
        idle();
        chk("miss cnt 0", dut.r_cnt, 0);

        // Fill to the outstanding limit with the host holding off responses.
        h.d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(c_GET, 2'd2, 32'h100 + 32'(4 * i), 4'hF);
            cyc();
        end
        chk("full cnt 4", dut.r_cnt, 4);
        chk("model depth 4", q.size(), 4);
        req(c_GET, 2'd2, 32'h110, 4'hF);
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'h0000_0100;
        @(negedge clk);
        chk("full a_ready", h_rsp.a_ready, 0);
        chk("full dev a_valid", dev_req.a_valid, 0);
        cyc();
        h.d_ready = 1'b1;
        @(negedge clk);
        chk("full ret a_ready", h_rsp.a_ready, 1);
        cyc();
        chk("full acc+ret cnt", dut.r_cnt, 4);
        h.a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dev_rsp.d_data = 32'h0000_0200 + 32'(i);
            cyc();
        end
        dev_rsp.d_valid = 1'b0;
        chk("drain cnt 0", dut.r_cnt, 0);
        chk("model depth 0", q.size(), 0);

        // Target switch waits for the last device response.
        req(c_GET, 2'd2, 32'h20, 4'hF);
        cyc();
        req(c_GET, 2'd2, 32'h24, 4'hF);
        cyc();
        req(c_GET, 2'd2, 32'h2000, 4'hF);
        @(negedge clk);
        chk("switch wait a_ready", h_rsp.a_ready, 0);
        chk("switch wait err a_valid", err_req.a_valid, 0);
        cyc();
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'h0000_0020;
        @(negedge clk);
        chk("switch cnt2 a_ready", h_rsp.a_ready, 0);
        cyc();
        dev_rsp.d_data = 32'h0000_0024;
        @(negedge clk);
        chk("switch last ret a_ready", h_rsp.a_ready, 1);
        chk("switch err a_valid", err_req.a_valid, 1);
        cyc();
        h.a_valid = 1'b0;
        chk("switch tgt", dut.r_tgt, 1);
        chk("switch cnt", dut.r_cnt, 1);
        @(negedge clk);
        chk("stray dev d_ready", dev_req.d_ready, 0);
        chk("stray d_valid", h_rsp.d_valid, 0);
        err_rsp.d_valid = 1'b1;
        err_rsp.d_error = 1'b1;
        @(negedge clk);
        chk("switch err d_error", h_rsp.d_error, 1);
        cyc();
        idle();
        chk("switch cnt 0", dut.r_cnt, 0);

        // Misaligned word Get inside the window.
        req(c_GET, 2'd2, 32'h0000_0002, 4'hF);
        @(negedge clk);
`ifdef TLUL_STEER_ALIGN_CHK_EN
        chk("misalign err a_valid", err_req.a_valid, 1);
        chk("misalign dev a_valid", dev_req.a_valid, 0);
`else
        chk("misalign dev a_valid", dev_req.a_valid, 1);
        chk("misalign err a_valid", err_req.a_valid, 0);
`endif
        cyc();
        h.a_valid       = 1'b0;
        dev_rsp.d_valid = 1'b1;
        err_rsp.d_valid = 1'b1;
        err_rsp.d_error = 1'b1;
        @(negedge clk);
`ifdef TLUL_STEER_ALIGN_CHK_EN
        chk("misalign d_error", h_rsp.d_error, 1);
`else
        chk("misalign d_error", h_rsp.d_error, 0);
`endif
        cyc();
        idle();

        // Partial write with a lane outside the addressed byte, then a clean full write.
        req(c_PUT_PARTIAL_DATA, 2'd0, 32'h0000_0004, 4'b0011);
        cyc();
        h.a_valid       = 1'b0;
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_opcode = c_ACCESS_ACK;
        err_rsp.d_valid = 1'b1;
        err_rsp.d_error = 1'b1;
        err_rsp.d_opcode = c_ACCESS_ACK;
        cyc();
        idle();
        req(c_PUT_FULL_DATA, 2'd2, 32'h0000_0FFC, 4'hF);
        @(negedge clk);
        chk("top of window dev a_valid", dev_req.a_valid, 1);
        cyc();
        h.a_valid        = 1'b0;
        dev_rsp.d_valid  = 1'b1;
        dev_rsp.d_opcode = c_ACCESS_ACK;
        cyc();
        idle();
        cyc();
        chk("final cnt 0", dut.r_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
